// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : iterative MIPS-style HI/LO multiply/divide unit.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
// Optional divider datapath is enabled by defining macro MDU_DIV_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] C_LAST_ITER = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  p_q, p_d;
  logic [W-1:0]    m_q;
  logic            neg_q;
  logic            busy_q, done_q, dbz_q;
  logic [W-1:0]    hi_q, lo_q;

  logic            w_signed, w_a_neg, w_b_neg, w_go;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_prod;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & src_a[W-1];
  assign w_b_neg  = w_signed & src_b[W-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
`ifdef MDU_DIV_EN
  assign w_go     = (op[2] == 1'b0);
`else
  assign w_go     = (op[2:1] == 2'b00);
`endif

  // Multiply: p holds {partial product, remaining multiplier bits}.
  assign w_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
  assign w_prod = neg_q ? -p_q : p_q;

`ifdef MDU_DIV_EN
  logic            is_div_q, rneg_q, bzero_q;
  logic [W:0]      w_rsh, w_diff;
  logic [W-1:0]    w_quo, w_rem;

  // Divide: p holds {partial remainder, dividend bits shifting into quotient}.
  assign w_rsh  = {p_q[2*W-1:W], p_q[W-1]};
  assign w_diff = w_rsh - {1'b0, m_q};
  assign w_quo  = neg_q  ? -p_q[W-1:0]   : p_q[W-1:0];
  assign w_rem  = rneg_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];

  always_comb begin
    p_d = {w_sum, p_q[W-1:1]};
    if (is_div_q) begin
      if (w_diff[W]) p_d = {w_rsh[W-1:0], p_q[W-2:0], 1'b0};
      else           p_d = {w_diff[W-1:0], p_q[W-2:0], 1'b1};
    end
  end
`else
  always_comb begin
    p_d = {w_sum, p_q[W-1:1]};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (w_go) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              neg_q   <= w_a_neg ^ w_b_neg;
`ifdef MDU_DIV_EN
              is_div_q <= op[1];
              rneg_q   <= w_a_neg;
              bzero_q  <= (src_b == '0);
              if (op[1]) begin
                m_q <= w_b_mag;
                p_q <= {{W{1'b0}}, w_a_mag};
              end else begin
                m_q <= w_a_mag;
                p_q <= {{W{1'b0}}, w_b_mag};
              end
`else
              m_q <= w_a_mag;
              p_q <= {{W{1'b0}}, w_b_mag};
`endif
            end else if (op == 3'd4) begin
              hi_q <= src_a;
            end else if (op == 3'd5) begin
              lo_q <= src_a;
            end
          end
        end
        S_RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == C_LAST_ITER) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            dbz_q <= bzero_q;
            // A zero divisor leaves HI/LO holding their previous contents.
            if (!bzero_q) begin
              hi_q <= w_rem;
              lo_q <= w_quo;
            end
          end else begin
            hi_q <= w_prod[2*W-1:W];
            lo_q <= w_prod[W-1:0];
          end
`else
          hi_q <= w_prod[2*W-1:W];
          lo_q <= w_prod[W-1:0];
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : randomized bench for mult_div_unit with a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int DW  = 32;
  localparam int LAT = DW + 1;
`ifdef MDU_DIV_EN
  localparam int MAX_OP = 3;
`else
  localparam int MAX_OP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] src_a = '0;
  logic [DW-1:0] src_b = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mult_div_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic result of one operation, straight from the signed/unsigned rules.
  function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl,
                                   output logic wr, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1; dz = 1'b0; rh = '0; rl = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd2: if (b == 0) begin wr = 1'b0; dz = 1'b1; end
            else begin rl = 32'(sa / sb); rh = 32'(sa % sb); end
      3'd3: if (b == 0) begin wr = 1'b0; dz = 1'b1; end
            else begin rl = a / b; rh = a % b; end
      default: wr = 1'b0;
    endcase
  endfunction

  // Reference model state
  int          m_cnt;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done, m_dbz, p_wr, p_dbz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
      p_hi = '0; p_lo = '0; p_wr = 1'b0; p_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_dbz  = p_dbz;
          if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (start) begin
        if (int'(op) <= MAX_OP) begin
          model_op(op, src_a, src_b, p_hi, p_lo, p_wr, p_dbz);
          m_cnt = LAT;
        end else if (op == 3'd4) m_hi = src_a;
        else if (op == 3'd5) m_lo = src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", busy, m_cnt != 0);
      check("done", done, m_done);
      check("div_by_zero", div_by_zero, m_dbz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    bit ok = 1'b0;
    nbusy = busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin lat = k; ok = 1'b1; break; end
    end
    check("done_timeout", ok, 1'b1);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, nb, ndone;
    logic [31:0] th, tl, sv_hi, sv_lo;
    logic tw, tz;

    // Pin the model against hand-computed values.
    model_op(3'd0, 32'd7, 32'hFFFF_FFFD, th, tl, tw, tz);
    check("model_mult_hi", th, 32'hFFFF_FFFF);
    check("model_mult_lo", tl, 32'hFFFF_FFEB);
    model_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, th, tl, tw, tz);
    check("model_ovf_lo", tl, 32'h8000_0000);
    check("model_ovf_hi", th, 32'd0);

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dbz", div_by_zero, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Signed multiply, latency and busy length
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, nb);
    check("mult_latency", lat, LAT);
    check("mult_busy_cycles", nb, LAT);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

`ifdef MDU_DIV_EN
    issue(3'd3, 32'd100, 32'd7);
    wait_done(lat, nb);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, nb);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_flag", div_by_zero, 1'b0);

    issue(3'd4, 32'h1234, 32'd0);
    check("mthi_busy", busy, 1'b0);
    check("mthi_hi", hi, 32'h1234);
    sv_lo = lo;
    issue(3'd2, 32'd5, 32'd0);
    wait_done(lat, nb);
    check("dbz_latency", lat, LAT);
    check("dbz_flag", div_by_zero, 1'b1);
    check("dbz_hi", hi, 32'h1234);
    check("dbz_lo", lo, sv_lo);
`else
    sv_hi = hi; sv_lo = lo;
    issue(3'd3, 32'd100, 32'd7);
    nb = 0; ndone = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) nb++;
      if (done) ndone++;
      @(negedge clk);
    end
    check("nodiv_busy", nb, 0);
    check("nodiv_done", ndone, 0);
    check("nodiv_hi", hi, sv_hi);
    check("nodiv_lo", lo, sv_lo);
    issue(3'd5, 32'h55AA, 32'd0);
    check("mtlo_busy", busy, 1'b0);
    check("mtlo_lo", lo, 32'h55AA);
`endif

    // Start while busy must be ignored
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'd1);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignored_start_dones", ndone, 0);

    // Reset in the middle of an operation aborts it
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    pulse_reset();
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_dones", ndone, 0);
    issue(3'd0, 32'd3, 32'd4);
    wait_done(lat, nb);
    check("post_rst_lo", lo, 32'd12);
    check("post_rst_hi", hi, 32'd0);

    // Back-to-back: start in the done cycle is accepted
    issue(3'd0, 32'd5, 32'd6);
    wait_done(lat, nb);
    start = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done(lat, nb);
    check("b2b_lo", lo, 32'd81);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      op    = 3'($urandom_range(0, 7));
      src_a = rnd_val();
      src_b = rnd_val();
      if (($urandom % 800) == 0) pulse_reset();
    end
    start = 1'b0;
    repeat (LAT + 5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
